// File: rtl/frame_stream_writer.sv
// frame_stream_writer: drains one frame of a valid/ready pixel stream into a linear framebuffer write port
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_start, i_abort                  arm one frame / cancel the frame in progress
//   i_data_valid, i_data, o_data_ready  incoming pixel stream
//   i_mem_stall                       framebuffer cannot take a write this cycle
//   o_mem_we, o_mem_addr, o_mem_data  registered framebuffer write (1-cycle latency)
//   o_busy                            frame capture in progress (WRITE or DONE)
//   o_line_done, o_frame_done         pulses coincident with the last write of a line / frame
module frame_stream_writer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_data_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_ready,
    input  logic              i_mem_stall,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_busy,
    output logic              o_line_done,
    output logic              o_frame_done
);
    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t r_state, w_next;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic w_ready, w_xfer, w_last_x, w_last_y, w_last, w_start;
    assign w_start      = (r_state == IDLE) & i_start;
    assign w_ready      = (r_state == WRITE) & ~i_mem_stall & ~i_abort;
    assign w_xfer       = i_data_valid & w_ready;
    assign w_last_x     = r_x == X_W'(IMG_W - 1);
    assign w_last_y     = r_y == Y_W'(IMG_H - 1);
    assign w_last       = w_last_x & w_last_y;
    assign o_data_ready = w_ready;
    assign o_busy       = r_state != IDLE;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_start)                             w_next = WRITE;
        else if (r_state == WRITE && i_abort)    w_next = IDLE;
        else if (w_xfer && w_last)               w_next = DONE;
        else if (r_state == DONE)                w_next = IDLE;
    end
    // Position counters: the linear address runs alongside x/y so no y*IMG_W multiply is needed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (w_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (w_xfer) begin
            r_x    <= w_last_x ? '0 : r_x + 1'b1;
            r_y    <= w_last_x ? (w_last_y ? '0 : r_y + 1'b1) : r_y;
            r_addr <= w_last ? '0 : r_addr + 1'b1;
        end
    end
    // Address and data hold their last values when no beat is transferred.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_line_done  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_mem_we     <= w_xfer;
            o_line_done  <= w_xfer & w_last_x;
            o_frame_done <= w_xfer & w_last;
            if (w_xfer) begin
                o_mem_addr <= r_addr;
                o_mem_data <= i_data;
            end
        end
    end
endmodule

// File: tb/tb_frame_stream_writer.sv
// tb_frame_stream_writer: randomized and directed checks of frame_stream_writer against a pixel-count model
module tb_frame_stream_writer;
    localparam int W = 4, H = 2, AW = 3, N = W * H;
    logic clk = 0, rst = 1, start = 0, abort = 0, valid = 0, stall = 0;
    logic [7:0] data = 0;
    logic ready, we, busy, ld, fd;
    logic [AW-1:0] addr;
    logic [7:0] mdata;
    always #5 clk = ~clk;
    frame_stream_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_data_valid(valid), .i_data(data), .o_data_ready(ready),
        .i_mem_stall(stall), .o_mem_we(we), .o_mem_addr(addr), .o_mem_data(mdata),
        .o_busy(busy), .o_line_done(ld), .o_frame_done(fd)
    );
    int tests = 0, fails = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: a frame is just a running pixel count; the address is the count itself.
    bit m_act = 0, m_done = 0;
    int m_n = 0;
    logic e_we = 0, e_ld = 0, e_fd = 0;
    logic [AW-1:0] e_addr = 0;
    logic [7:0] e_data = 0;
    int n_wr = 0, n_ld = 0, n_fd = 0;
    int log_addr [0:4095];
    int log_data [0:4095];
    bit log_ld [0:4095];
    always @(negedge clk) begin : cmp
        bit e_rdy, x;
        if (rst) begin
            m_act = 0; m_done = 0; m_n = 0;
            e_we = 0; e_ld = 0; e_fd = 0; e_addr = 0; e_data = 0;
            chk("rst_we", we, 0); chk("rst_addr", addr, 0); chk("rst_data", mdata, 0);
            chk("rst_busy", busy, 0); chk("rst_ready", ready, 0);
            chk("rst_ld", ld, 0); chk("rst_fd", fd, 0);
        end else begin
            e_rdy = m_act && !stall && !abort;
            chk("ready", ready, e_rdy);
            chk("busy", busy, m_act || m_done);
            chk("we", we, e_we);
            chk("addr", addr, e_addr);
            chk("data", mdata, e_data);
            chk("line_done", ld, e_ld);
            chk("frame_done", fd, e_fd);
            if (we === 1'b1) begin
                log_addr[n_wr] = int'(addr);
                log_data[n_wr] = int'(mdata);
                log_ld[n_wr] = ld;
                n_wr++;
            end
            if (ld === 1'b1) n_ld++;
            if (fd === 1'b1) n_fd++;
            x = valid && e_rdy;
            e_we = x;
            if (x) begin
                e_addr = AW'(m_n);
                e_data = data;
            end
            e_ld = x && (m_n % W == W - 1);
            e_fd = x && (m_n == N - 1);
            if (m_done) m_done = 0;
            else if (!m_act) begin
                if (start) begin
                    m_act = 1;
                    m_n = 0;
                end
            end else if (abort) m_act = 0;
            else if (x) begin
                if (m_n == N - 1) begin
                    m_act = 0;
                    m_done = 1;
                end else m_n++;
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int b, b2, fb, lb, k;
        repeat (3) cyc();
        rst = 0;
        cyc();
        // 1: back-to-back frame
        b = n_wr; fb = n_fd; lb = n_ld;
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 8; i++) begin
            valid = 1; data = 8'(8'h10 + i); cyc();
        end
        valid = 0;
        chk("t1_fd_pulse", fd, 1); chk("t1_last_addr", addr, 7);
        chk("t1_busy_done", busy, 1); chk("t1_ready_done", ready, 0);
        cyc();
        chk("t1_busy_after", busy, 0);
        cyc();
        chk("t1_writes", n_wr - b, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_seq_addr", log_addr[b + i], i);
            chk("t1_seq_data", log_data[b + i], 32'h10 + i);
        end
        chk("t1_ld_at3", log_ld[b + 3], 1); chk("t1_ld_at7", log_ld[b + 7], 1);
        chk("t1_ld_count", n_ld - lb, 2); chk("t1_fd_count", n_fd - fb, 1);
        // 2: no start
        b = n_wr;
        valid = 1; repeat (10) cyc(); valid = 0;
        chk("t2_writes", n_wr - b, 0);
        // 3: stalls and random gaps
        b = n_wr; fb = n_fd;
        start = 1; cyc(); start = 0;
        k = 0;
        while (n_wr - b < 8 && k < 200) begin
            stall = (k >= 2 && k <= 4);
            valid = ($urandom_range(0, 9) < 7);
            data = 8'($urandom);
            cyc();
            k++;
        end
        stall = 0; valid = 0;
        repeat (3) cyc();
        chk("t3_writes", n_wr - b, 8);
        for (int i = 0; i < 8; i++) chk("t3_seq_addr", log_addr[b + i], i);
        chk("t3_fd_count", n_fd - fb, 1);
        // 4: abort after 3 beats
        b = n_wr; fb = n_fd;
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 3; i++) begin
            valid = 1; data = 8'(8'h30 + i); cyc();
        end
        abort = 1; valid = 1; cyc(); abort = 0; valid = 0;
        chk("t4_idle", busy, 0);
        repeat (2) cyc();
        chk("t4_writes", n_wr - b, 3);
        for (int i = 0; i < 3; i++) chk("t4_seq_addr", log_addr[b + i], i);
        chk("t4_no_fd", n_fd - fb, 0);
        start = 1; cyc(); start = 0;
        b2 = n_wr;
        valid = 1; data = 8'hA0; cyc(); valid = 0; cyc();
        chk("t4_restart_n", n_wr - b2, 1); chk("t4_restart_addr", log_addr[b2], 0);
        // 5: async reset mid-frame
        valid = 1; data = 8'hB1; cyc(); data = 8'hB2; cyc();
        #1 rst = 1;
        #1;
        chk("t5_we", we, 0); chk("t5_addr", addr, 0); chk("t5_data", mdata, 0);
        chk("t5_ld", ld, 0); chk("t5_fd", fd, 0); chk("t5_busy", busy, 0); chk("t5_ready", ready, 0);
        valid = 0;
        cyc();
        rst = 0;
        cyc();
        start = 1; cyc(); start = 0;
        b = n_wr;
        valid = 1; data = 8'h55; cyc(); valid = 0; cyc();
        chk("t5_restart_n", n_wr - b, 1); chk("t5_restart_addr", log_addr[b], 0);
        valid = 1; repeat (7) cyc(); valid = 0; repeat (2) cyc();
        // 6: start ignored in WRITE and DONE
        b = n_wr; fb = n_fd;
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 8; i++) begin
            valid = 1; data = 8'(i); start = (i == 3); cyc();
        end
        start = 1; valid = 0; cyc(); start = 0;
        valid = 1; repeat (3) cyc(); valid = 0; cyc();
        chk("t6_one_frame", n_wr - b, 8); chk("t6_idle", busy, 0);
        start = 1; cyc(); start = 0;
        valid = 1; repeat (8) cyc(); valid = 0; repeat (2) cyc();
        chk("t6_two_frames", n_wr - b, 16);
        for (int i = 0; i < 8; i++) chk("t6_f2_addr", log_addr[b + 8 + i], i);
        chk("t6_fd_count", n_fd - fb, 2);
        // 7: random soak
        repeat (600) begin
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 29) == 0);
            stall = ($urandom_range(0, 4) == 0);
            valid = ($urandom_range(0, 9) < 7);
            data = 8'($urandom);
            cyc();
        end
        start = 0; abort = 0; stall = 0; valid = 0;
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
